// File: rtl/gpio_debounce.sv
// Multi-channel pad synchroniser and debouncer with rise/fall event pulses.
// One free-running prescaler is shared; each channel has its own stability counter.
module gpio_debounce #(
  parameter int unsigned N_CHANNELS   = 5,
  parameter int unsigned PRESCALE_DIV = 36000,
  parameter int unsigned STABLE_TICKS = 8,
  parameter logic [N_CHANNELS-1:0] RESET_VALUE = {N_CHANNELS{1'b1}}
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CHANNELS-1:0] in,
  output logic [N_CHANNELS-1:0] out,
  output logic [N_CHANNELS-1:0] rise,
  output logic [N_CHANNELS-1:0] fall
);

  localparam int unsigned PcntW = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
  localparam int unsigned CntW  = $clog2(STABLE_TICKS + 1);

  localparam logic [PcntW-1:0] PcntLast = PcntW'(PRESCALE_DIV - 1);
  localparam logic [CntW-1:0]  CntLast  = CntW'(STABLE_TICKS - 1);

  logic [N_CHANNELS-1:0] sync1_q;
  logic [N_CHANNELS-1:0] sync_q;

  logic [PcntW-1:0] pcnt_q, pcnt_d;
  logic             tick;

  logic [N_CHANNELS-1:0][CntW-1:0] cnt_q, cnt_d;
  logic [N_CHANNELS-1:0]           out_q, out_d;
  logic [N_CHANNELS-1:0]           rise_q, rise_d;
  logic [N_CHANNELS-1:0]           fall_q, fall_d;

  // Two-flop synchroniser; both stages idle at the pad pull-up level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= RESET_VALUE;
      sync_q  <= RESET_VALUE;
    end else begin
      sync1_q <= in;
      sync_q  <= sync1_q;
    end
  end

  // With PRESCALE_DIV == 1 the counter sits at 0 and tick is permanently high.
  always_comb begin
    tick   = (pcnt_q == PcntLast);
    pcnt_d = tick ? '0 : pcnt_q + PcntW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

  always_comb begin
    out_d  = out_q;
    rise_d = '0;
    fall_d = '0;
    cnt_d  = cnt_q;
    for (int i = 0; i < int'(N_CHANNELS); i++) begin
      if (sync_q[i] == out_q[i]) begin
        // Any return to the current level restarts the stability window.
        cnt_d[i] = '0;
      end else if (tick && (cnt_q[i] == CntLast)) begin
        out_d[i]  = sync_q[i];
        cnt_d[i]  = '0;
        rise_d[i] = sync_q[i];
        fall_d[i] = ~sync_q[i];
      end else if (tick) begin
        cnt_d[i] = cnt_q[i] + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      out_q  <= RESET_VALUE;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign out  = out_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: tb/tb_gpio_debounce.sv
// Directed self-checking bench for gpio_debounce: main instance (div 4, 3 ticks)
// and a pass-through instance (div 1, 1 tick).
module tb_gpio_debounce;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] in_a, out_a, rise_a, fall_a;
  logic [1:0] in_b, out_b, rise_b, fall_b;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  // Cycle index since reset release; prescaler phase is cyc % 4.
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  gpio_debounce #(
    .N_CHANNELS  (2),
    .PRESCALE_DIV(4),
    .STABLE_TICKS(3),
    .RESET_VALUE (2'b11)
  ) dut_a (
    .clk (clk),
    .rst (rst),
    .in  (in_a),
    .out (out_a),
    .rise(rise_a),
    .fall(fall_a)
  );

  gpio_debounce #(
    .N_CHANNELS  (2),
    .PRESCALE_DIV(1),
    .STABLE_TICKS(1),
    .RESET_VALUE (2'b11)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .in  (in_b),
    .out (out_b),
    .rise(rise_b),
    .fall(fall_b)
  );

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_out(input string tag, input logic [1:0] exp, input int budget,
                          output int edges);
    edges = 0;
    while (out_a !== exp && edges < budget) begin
      step(1);
      edges++;
    end
    chk(tag, out_a, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] acc_or;
    logic [1:0] acc_and;
    logic [1:0] rise_or;
    logic [1:0] v6 [20];
    logic [1:0] e_out, e_prev;
    int         e, f, t, nfall;

    v6 = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b11, 2'b10, 2'b10, 2'b00, 2'b11,
           2'b11, 2'b00, 2'b01, 2'b10, 2'b10, 2'b11, 2'b00, 2'b00, 2'b11, 2'b11};

    // 1: reset state, then first debounce from the reset level.
    in_a = 2'b00;
    in_b = 2'b11;
    step(3);
    chk("rst out", out_a, 2'b11);
    chk("rst rise", rise_a, 2'b00);
    chk("rst fall", fall_a, 2'b00);
    chk("rst out_b", out_b, 2'b11);
    rst = 1'b0;
    acc_or = 2'b00;
    for (int i = 0; i < 11; i++) begin
      step(1);
      acc_or |= rise_a | fall_a;
    end
    chk("s1 out before tick 3", out_a, 2'b11);
    chk("s1 early pulses", acc_or, 2'b00);
    step(1);
    chk("s1 out after", out_a, 2'b00);
    chk("s1 fall pulse", fall_a, 2'b11);
    chk("s1 rise quiet", rise_a, 2'b00);
    step(1);
    chk("s1 fall cleared", fall_a, 2'b00);
    chk("s1 out held", out_a, 2'b00);

    // 2: 9-cycle low excursions aligned so they see only two ticks.
    in_a = 2'b11;
    wait_out("s2 restore", 2'b11, 30, e);
    while (cyc % 4 != 2) step(1);
    acc_and = 2'b11;
    acc_or  = 2'b00;
    rise_or = 2'b00;
    for (int r = 0; r < 20; r++) begin
      in_a = 2'b10;
      for (int i = 0; i < 9; i++) begin
        step(1);
        acc_and &= out_a;
        acc_or  |= fall_a;
        rise_or |= rise_a;
      end
      in_a = 2'b11;
      for (int i = 0; i < 3; i++) begin
        step(1);
        acc_and &= out_a;
        acc_or  |= fall_a;
        rise_or |= rise_a;
      end
    end
    step(4);
    acc_and &= out_a;
    chk("s2 glitch out", acc_and, 2'b11);
    chk("s2 glitch fall", acc_or, 2'b00);
    chk("s2 glitch rise", rise_or, 2'b00);

    // 3: bounce every 3 cycles, final edge held low.
    nfall   = 0;
    rise_or = 2'b00;
    for (int k = 0; k < 4; k++) begin
      in_a = (k % 2 == 0) ? 2'b10 : 2'b11;
      for (int i = 0; i < 3; i++) begin
        step(1);
        if (fall_a[0]) nfall++;
        rise_or |= rise_a;
      end
    end
    in_a = 2'b10;
    f = cyc;
    t = f + 2;
    while (t % 4 != 3) t++;
    e = 0;
    while (out_a[0] !== 1'b0 && e < 30) begin
      step(1);
      e++;
      if (fall_a[0]) nfall++;
      rise_or |= rise_a;
    end
    chk_int("s3 latency", e, t + 9 - f);
    chk_int("s3 latency window", int'(e >= 11 && e <= 14), 1);
    for (int i = 0; i < 3; i++) begin
      step(1);
      if (fall_a[0]) nfall++;
      rise_or |= rise_a;
    end
    chk_int("s3 fall pulses", nfall, 1);
    chk("s3 rise quiet", rise_or, 2'b00);
    chk("s3 out", out_a, 2'b10);

    // 4: opposite transitions on both channels in the same cycle.
    in_a = 2'b01;
    wait_out("s4 setup", 2'b01, 30, e);
    step(2);
    in_a = 2'b10;
    e = 0;
    while (out_a === 2'b01 && e < 30) begin
      step(1);
      e++;
    end
    chk("s4 out", out_a, 2'b10);
    chk("s4 rise", rise_a, 2'b10);
    chk("s4 fall", fall_a, 2'b01);
    step(1);
    chk("s4 rise cleared", rise_a, 2'b00);
    chk("s4 fall cleared", fall_a, 2'b00);

    // 5: reset mid-count (cnt[0] == 2) restarts the whole window.
    in_a = 2'b11;
    wait_out("s5 setup", 2'b11, 30, e);
    while (cyc % 4 != 2) step(1);
    in_a = 2'b10;
    step(10);
    rst = 1'b1;
    #1;
    chk("s5 rst out", out_a, 2'b11);
    chk("s5 rst pulses", rise_a | fall_a, 2'b00);
    step(1);
    rst = 1'b0;
    acc_or = 2'b00;
    for (int i = 0; i < 11; i++) begin
      step(1);
      acc_or |= rise_a | fall_a;
    end
    chk("s5 out before", out_a, 2'b11);
    chk("s5 early pulses", acc_or, 2'b00);
    step(1);
    chk("s5 out after", out_a, 2'b10);
    chk("s5 fall pulse", fall_a, 2'b01);

    // 6: div 1, 1 tick: out tracks in three edges later with matching pulses.
    for (int k = 0; k < 20; k++) begin
      in_b = v6[k];
      step(1);
      e_out  = (k >= 2) ? v6[k-2] : 2'b11;
      e_prev = (k >= 3) ? v6[k-3] : 2'b11;
      chk("s6 out", out_b, e_out);
      chk("s6 rise", rise_b, e_out & ~e_prev);
      chk("s6 fall", fall_b, ~e_out & e_prev);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
